// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: icache reads and dcache reads/writes
// share one command channel; write bursts follow their command.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ic_req_valid,
  output logic                ic_req_ready,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  input  logic [3:0]          ic_req_tag,
  input  logic                dc_req_valid,
  output logic                dc_req_ready,
  input  logic                dc_req_rw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic [3:0]          dc_req_tag,
  input  logic                dc_data_valid,
  output logic                dc_data_ready,
  input  logic [DATA_W-1:0]   dc_data_bits,
  input  logic [DATA_W/8-1:0] dc_data_mask,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [4:0]          mem_req_tag,
  output logic                mem_req_data_valid,
  input  logic                mem_req_data_ready,
  output logic [DATA_W-1:0]   mem_req_data_bits,
  output logic [DATA_W/8-1:0] mem_req_data_mask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  input  logic [4:0]          mem_resp_tag,
  output logic                ic_resp_valid,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [3:0]          resp_tag
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA
  } state_t;

  typedef enum logic {
    GNT_IC,
    GNT_DC
  } gnt_t;

  state_t           r_state;
  state_t           w_state_nxt;
  gnt_t             r_gnt;
  gnt_t             w_gnt_nxt;
  gnt_t             r_last;
  gnt_t             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sel_dc;
  logic             w_cmd_hs;
  logic             w_data_hs;

  assign w_sel_dc = (r_gnt == GNT_DC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= GNT_IC;
      r_last  <= GNT_DC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_gnt_nxt          = r_gnt;
    w_last_nxt         = r_last;
    w_cnt_nxt          = r_cnt;
    w_cmd_hs           = 1'b0;
    w_data_hs          = 1'b0;
    mem_req_valid      = 1'b0;
    ic_req_ready       = 1'b0;
    dc_req_ready       = 1'b0;
    mem_req_data_valid = 1'b0;
    dc_data_ready      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ic_req_valid || dc_req_valid) begin
          // On a tie the side not served last wins
          if (ic_req_valid && dc_req_valid)
            w_gnt_nxt = (r_last == GNT_DC) ? GNT_IC : GNT_DC;
          else
            w_gnt_nxt = dc_req_valid ? GNT_DC : GNT_IC;
          w_last_nxt  = w_gnt_nxt;
          w_state_nxt = CMD;
        end
      end
      CMD: begin
        mem_req_valid = w_sel_dc ? dc_req_valid : ic_req_valid;
        ic_req_ready  = !w_sel_dc && mem_req_ready;
        dc_req_ready  = w_sel_dc && mem_req_ready;
        w_cmd_hs      = mem_req_valid && mem_req_ready;
        if (w_cmd_hs) begin
          if (w_sel_dc && dc_req_rw) begin
            w_state_nxt = WDATA;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      WDATA: begin
        mem_req_data_valid = dc_data_valid;
        dc_data_ready      = mem_req_data_ready;
        w_data_hs          = dc_data_valid && mem_req_data_ready;
        if (w_data_hs) begin
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign mem_req_addr = w_sel_dc ? dc_req_addr : ic_req_addr;
  assign mem_req_tag  = {w_sel_dc, w_sel_dc ? dc_req_tag : ic_req_tag};
  assign mem_req_rw   = w_sel_dc && dc_req_rw;

  assign mem_req_data_bits = dc_data_bits;
  assign mem_req_data_mask = dc_data_mask;

  // Responses bypass the FSM entirely
  assign ic_resp_valid = mem_resp_valid && !mem_resp_tag[4];
  assign dc_resp_valid = mem_resp_valid && mem_resp_tag[4];
  assign resp_data     = mem_resp_data;
  assign resp_tag      = mem_resp_tag[3:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random
// traffic checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = DW / 8;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_ready;
  logic [AW-1:0] ic_req_addr;
  logic [3:0]    ic_req_tag;
  logic          dc_req_valid, dc_req_ready, dc_req_rw;
  logic [AW-1:0] dc_req_addr;
  logic [3:0]    dc_req_tag;
  logic          dc_data_valid, dc_data_ready;
  logic [DW-1:0] dc_data_bits;
  logic [MW-1:0] dc_data_mask;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [4:0]    mem_req_tag;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic [MW-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [4:0]    mem_resp_tag;
  logic          ic_resp_valid, dc_resp_valid;
  logic [DW-1:0] resp_data;
  logic [3:0]    resp_tag;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_tag(dc_req_tag),
    .dc_data_valid(dc_data_valid), .dc_data_ready(dc_data_ready),
    .dc_data_bits(dc_data_bits), .dc_data_mask(dc_data_mask),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_tag(mem_resp_tag),
    .ic_resp_valid(ic_resp_valid), .dc_resp_valid(dc_resp_valid),
    .resp_data(resp_data), .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    t;
    logic          rw;
  } cmd_t;

  cmd_t          icq[$];
  cmd_t          dcq[$];
  logic [DW-1:0] pb[$];
  logic [MW-1:0] pm[$];

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ic_req_valid       = 1'b0;
    ic_req_addr        = '0;
    ic_req_tag         = '0;
    dc_req_valid       = 1'b0;
    dc_req_rw          = 1'b0;
    dc_req_addr        = '0;
    dc_req_tag         = '0;
    dc_data_valid      = 1'b0;
    dc_data_bits       = '0;
    dc_data_mask       = '0;
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_data      = '0;
    mem_resp_tag       = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mrv"}, DW'(mem_req_valid), DW'(0));
    chk({tag, "_icr"}, DW'(ic_req_ready), DW'(0));
    chk({tag, "_dcr"}, DW'(dc_req_ready), DW'(0));
    chk({tag, "_mdv"}, DW'(mem_req_data_valid), DW'(0));
    chk({tag, "_ddr"}, DW'(dc_data_ready), DW'(0));
  endtask

  initial begin
    logic          found;
    logic          exp_src[3];
    logic          last_dc;
    logic          c_hs, d_hs, src;
    cmd_t          e;
    int            cyc;
    logic [DW-1:0] b0, b1;

    // reset with every input active: nothing may leak through
    set_idle();
    reset = 1'b1;
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    dc_data_valid = 1'b1;
    mem_req_ready = 1'b1;
    mem_req_data_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_quiet("rst");
    tick();
    reset = 1'b0;
    set_idle();
    tick();

    // single icache read
    ic_req_valid = 1'b1;
    ic_req_addr = AW'(28'h0000040);
    ic_req_tag = 4'h3;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("rd_idle_mrv", DW'(mem_req_valid), DW'(0));
    tick();
    @(negedge clk);
    chk("rd_mrv", DW'(mem_req_valid), DW'(1));
    chk("rd_tag", DW'(mem_req_tag), DW'(5'h03));
    chk("rd_rw", DW'(mem_req_rw), DW'(0));
    chk("rd_addr", DW'(mem_req_addr), DW'(28'h40));
    chk("rd_icr", DW'(ic_req_ready), DW'(1));
    chk("rd_dcr", DW'(dc_req_ready), DW'(0));
    tick();
    ic_req_valid = 1'b0;
    @(negedge clk);
    chk("rd_done_mrv", DW'(mem_req_valid), DW'(0));
    chk("rd_done_icr", DW'(ic_req_ready), DW'(0));
    tick();

    // tie right after reset: ic, dc, ic
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ic_req_valid = 1'b1;
    ic_req_addr = AW'(28'h123);
    ic_req_tag = 4'h1;
    dc_req_valid = 1'b1;
    dc_req_rw = 1'b0;
    dc_req_addr = AW'(28'hABCDE);
    dc_req_tag = 4'h9;
    mem_req_ready = 1'b1;
    exp_src[0] = 1'b0;
    exp_src[1] = 1'b1;
    exp_src[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int w = 0; w < 6 && !found; w++) begin
        @(negedge clk);
        if (mem_req_valid && mem_req_ready) begin
          found = 1'b1;
          chk("tie_src", DW'(mem_req_tag[4]), DW'(exp_src[k]));
        end
        tick();
      end
      if (!found) chk("tie_timeout", DW'(0), DW'(1));
    end

    // backpressure: dcache now owns the tie, held for 5 cycles
    mem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_mrv", DW'(mem_req_valid), DW'(1));
      chk("bp_addr", DW'(mem_req_addr), DW'(28'hABCDE));
      chk("bp_tag", DW'(mem_req_tag), DW'(5'h19));
      chk("bp_dcr", DW'(dc_req_ready), DW'(0));
      chk("bp_icr", DW'(ic_req_ready), DW'(0));
      tick();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_dcr", DW'(dc_req_ready), DW'(1));
    chk("bp_rel_icr", DW'(ic_req_ready), DW'(0));
    tick();
    set_idle();
    tick();

    // write interrupted by reset after two beats
    dc_req_valid = 1'b1;
    dc_req_rw = 1'b1;
    dc_req_addr = AW'(28'h55);
    dc_req_tag = 4'hA;
    mem_req_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("wr_mrv", DW'(mem_req_valid), DW'(1));
    chk("wr_rw", DW'(mem_req_rw), DW'(1));
    chk("wr_tag", DW'(mem_req_tag), DW'(5'h1A));
    tick();
    dc_req_valid = 1'b0;
    b0 = {$urandom, $urandom, $urandom, $urandom};
    b1 = {$urandom, $urandom, $urandom, $urandom};
    dc_data_valid = 1'b1;
    dc_data_bits = b0;
    dc_data_mask = 16'hF0F0;
    mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_tag = 5'h15;
    @(negedge clk);
    chk("wd_mdv", DW'(mem_req_data_valid), DW'(1));
    chk("wd_ddr", DW'(dc_data_ready), DW'(1));
    chk("wd_bits", mem_req_data_bits, b0);
    chk("wd_mask", DW'(mem_req_data_mask), DW'(16'hF0F0));
    chk("wd_rsp15_dc", DW'(dc_resp_valid), DW'(1));
    chk("wd_rsp15_ic", DW'(ic_resp_valid), DW'(0));
    chk("wd_rsp15_tag", DW'(resp_tag), DW'(4'h5));
    tick();
    dc_data_bits = b1;
    mem_resp_tag = 5'h07;
    @(negedge clk);
    chk("wd_bits1", mem_req_data_bits, b1);
    chk("wd_rsp07_ic", DW'(ic_resp_valid), DW'(1));
    chk("wd_rsp07_dc", DW'(dc_resp_valid), DW'(0));
    chk("wd_rsp07_tag", DW'(resp_tag), DW'(4'h7));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("mid_rst");
    tick();
    set_idle();
    ic_req_valid = 1'b1;
    ic_req_addr = AW'(28'h777);
    ic_req_tag = 4'h2;
    mem_req_ready = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 6 && !found; w++) begin
      @(negedge clk);
      if (ic_req_ready && ic_req_valid) begin
        found = 1'b1;
        chk("post_rst_tag", DW'(mem_req_tag), DW'(5'h02));
      end
      tick();
    end
    chk("post_rst_done", DW'(found), DW'(1));
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // random traffic against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      e.a = AW'($urandom);
      e.t = 4'($urandom);
      e.rw = 1'b0;
      icq.push_back(e);
      e.a = AW'($urandom);
      e.t = 4'($urandom);
      e.rw = 1'($urandom);
      dcq.push_back(e);
    end
    last_dc = 1'b1;
    cyc = 0;
    while ((icq.size() > 0 || dcq.size() > 0 || pb.size() > 0)
           && cyc < 4000) begin
      cyc++;
      ic_req_valid = icq.size() > 0;
      ic_req_addr = icq.size() > 0 ? icq[0].a : AW'($urandom);
      ic_req_tag = icq.size() > 0 ? icq[0].t : 4'($urandom);
      dc_req_valid = dcq.size() > 0;
      dc_req_addr = dcq.size() > 0 ? dcq[0].a : AW'($urandom);
      dc_req_tag = dcq.size() > 0 ? dcq[0].t : 4'($urandom);
      dc_req_rw = dcq.size() > 0 ? dcq[0].rw : 1'($urandom);
      if (pb.size() > 0) begin
        dc_data_valid = ($urandom % 4) != 0;
        dc_data_bits = pb[0];
        dc_data_mask = pm[0];
      end else begin
        dc_data_valid = 1'($urandom);
        dc_data_bits = {$urandom, $urandom, $urandom, $urandom};
        dc_data_mask = MW'($urandom);
      end
      mem_req_ready = ($urandom % 3) != 0;
      mem_req_data_ready = ($urandom % 3) != 0;
      mem_resp_valid = 1'($urandom);
      mem_resp_tag = 5'($urandom);
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("rsp_ic", DW'(ic_resp_valid),
          DW'(mem_resp_valid && !mem_resp_tag[4]));
      chk("rsp_dc", DW'(dc_resp_valid),
          DW'(mem_resp_valid && mem_resp_tag[4]));
      chk("rsp_tag", DW'(resp_tag), DW'(mem_resp_tag[3:0]));
      chk("rsp_data", resp_data, mem_resp_data);
      c_hs = 1'b0;
      d_hs = 1'b0;
      src = 1'b0;
      if (pb.size() > 0) begin
        chk("wb_mrv", DW'(mem_req_valid), DW'(0));
        chk("wb_mdv", DW'(mem_req_data_valid), DW'(dc_data_valid));
        chk("wb_ddr", DW'(dc_data_ready), DW'(mem_req_data_ready));
        if (dc_data_valid && mem_req_data_ready) begin
          d_hs = 1'b1;
          chk("wb_bits", mem_req_data_bits, pb[0]);
          chk("wb_mask", DW'(mem_req_data_mask), DW'(pm[0]));
        end
      end else begin
        chk("nw_mdv", DW'(mem_req_data_valid), DW'(0));
        chk("nw_ddr", DW'(dc_data_ready), DW'(0));
      end
      if (mem_req_valid && mem_req_ready) begin
        c_hs = 1'b1;
        if (icq.size() > 0 && dcq.size() > 0) src = !last_dc;
        else src = dcq.size() > 0;
        chk("cmd_src", DW'(mem_req_tag[4]), DW'(src));
        e = src ? dcq[0] : icq[0];
        chk("cmd_addr", DW'(mem_req_addr), DW'(e.a));
        chk("cmd_tag", DW'(mem_req_tag[3:0]), DW'(e.t));
        chk("cmd_rw", DW'(mem_req_rw), DW'(e.rw));
        chk("cmd_rdy", DW'(src ? dc_req_ready : ic_req_ready), DW'(1));
      end
      tick();
      if (d_hs) begin
        void'(pb.pop_front());
        void'(pm.pop_front());
      end
      if (c_hs) begin
        last_dc = src;
        if (src) begin
          e = dcq.pop_front();
          if (e.rw) begin
            for (int b = 0; b < NB; b++) begin
              pb.push_back({$urandom, $urandom, $urandom, $urandom});
              pm.push_back(MW'($urandom));
            end
          end
        end else begin
          void'(icq.pop_front());
        end
      end
    end
    if (cyc >= 4000) chk("rand_timeout", DW'(0), DW'(1));

    set_idle();
    tick();
    @(negedge clk);
    chk_quiet("end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
